// File: rtl/run_sequencer_if.sv
// Signal bundle between the run sequencer and its environment: time base,
// user controls, state-register feedback and the sequencer's status outputs.
interface run_sequencer_if #(
    parameter int W = 8
);
    logic         tick;
    logic         btn_start;
    logic         btn_stop;
    logic         cur_state;
    logic         NS;
    logic [1:0]   phase;
    logic [W-1:0] count;
    logic         done;
    logic         busy;
    logic         err;

    // Sequencer side
    modport slave (
        input  tick, btn_start, btn_stop, cur_state,
        output NS, phase, count, done, busy, err
    );

    // Environment side
    modport master (
        output tick, btn_start, btn_stop, cur_state,
        input  NS, phase, count, done, busy, err
    );
endinterface

// File: rtl/run_sequencer.sv
// Moore IDLE->ARM->RUN->DONE controller producing the next-state request for a
// one-bit state register, with tick-counted dwell and a register feedback check.
module run_sequencer #(
    parameter int W         = 8,
    parameter int ARM_TICKS = 3,
    parameter int RUN_TICKS = 5
) (
    input  logic            clk_main,
    input  logic            reset,
    run_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } phase_t;

    // Truncate to the counter width first so an over-wide value that lands on
    // zero still dwells one tick instead of stalling the sequence.
    function automatic logic [W-1:0] load_value(input int unsigned n);
        logic [W-1:0] v;
        v = n[W-1:0];
        if (v == {W{1'b0}}) begin
            v = W'(1);
        end
        return v;
    endfunction

    localparam logic [W-1:0] ARM_LOAD = load_value(ARM_TICKS);
    localparam logic [W-1:0] RUN_LOAD = load_value(RUN_TICKS);
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] ZERO     = {W{1'b0}};

    phase_t       phase_r, phase_s;
    logic [W-1:0] count_r, count_s;
    logic         done_r, done_s;
    logic         start_q_r;
    logic         ns_d_r;
    logic         qual_r;
    logic         err_r;
    logic         start_rise_s;
    logic         ns_s;

    assign start_rise_s = bus.btn_start & ~start_q_r;
    assign ns_s         = (phase_r == RUN);

    // FSM, dwell counter and done pulse registers
    always_ff @(posedge clk_main) begin
        if (reset) begin
            phase_r   <= IDLE;
            count_r   <= ZERO;
            done_r    <= 1'b0;
            start_q_r <= 1'b0;
        end else begin
            phase_r   <= phase_s;
            count_r   <= count_s;
            done_r    <= done_s;
            start_q_r <= bus.btn_start;
        end
    end

    // Next-state, next-count and done-pulse decode
    always_comb begin
        phase_s = phase_r;
        count_s = count_r;
        done_s  = 1'b0;
        case (phase_r)
            IDLE: begin
                if (start_rise_s && !bus.btn_stop) begin
                    phase_s = ARM;
                    count_s = ARM_LOAD;
                end else begin
                    phase_s = IDLE;
                    count_s = ZERO;
                end
            end
            ARM: begin
                if (bus.btn_stop) begin
                    phase_s = IDLE;
                    count_s = ZERO;
                end else if (bus.tick && count_r == ONE) begin
                    phase_s = RUN;
                    count_s = RUN_LOAD;
                end else if (bus.tick && count_r > ONE) begin
                    count_s = count_r - ONE;
                end else begin
                    count_s = count_r;
                end
            end
            RUN: begin
                if (bus.btn_stop) begin
                    phase_s = IDLE;
                    count_s = ZERO;
                end else if (bus.tick && count_r == ONE) begin
                    phase_s = DONE;
                    count_s = ZERO;
                    done_s  = 1'b1;
                end else if (bus.tick && count_r > ONE) begin
                    count_s = count_r - ONE;
                end else begin
                    count_s = count_r;
                end
            end
            DONE: begin
                if (bus.btn_stop || bus.tick) begin
                    phase_s = IDLE;
                    count_s = ZERO;
                end else begin
                    phase_s = DONE;
                    count_s = ZERO;
                end
            end
            default: begin
                phase_s = IDLE;
                count_s = ZERO;
            end
        endcase
    end

    // Feedback check: the register must echo last cycle's request; the first
    // cycle out of reset is skipped since ns_d has no real history yet.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            ns_d_r <= 1'b0;
            qual_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            ns_d_r <= ns_s;
            qual_r <= 1'b1;
            if (qual_r && (bus.cur_state != ns_d_r)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign bus.NS    = ns_s;
    assign bus.busy  = (phase_r == ARM) || (phase_r == RUN);
    assign bus.phase = phase_r;
    assign bus.count = count_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Moore controller that generates the 1-bit next-state request NS for the design's one-bit state register, and sequences it through IDLE -> ARM -> RUN -> DONE.
- Dwell time in each timed phase is counted in external tick pulses, with start/stop user controls.
- Monitors the state register's output (cur_state) against the value it requested one cycle earlier and flags any mismatch.
- Sits between the synchronized button/tick logic and the state register. Its NS output drives the register's NS input.

Parameters:
- W, 8, width of dwell counter and count output.
- ARM_TICKS, 3, number of tick pulses spent in ARM (0 treated as 1).
- RUN_TICKS, 5, number of tick pulses spent in RUN (0 treated as 1).

Ports:
- clk_main  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle enable pulse (time base), synchronous to clk_main.
- btn_start  input  1  synchronized start level; internally edge-detected.
- btn_stop  input  1  synchronized stop level; acts while high (level-sensitive).
- cur_state  input  1  output of the one-bit state register (registered copy of NS).
- NS  output  1  next-state request to state register; 1 only in RUN.
- phase  output  2  current FSM state: IDLE=00, ARM=01, RUN=10, DONE=11.
- count  output  W  remaining ticks in current timed phase.
- done  output  1  one-cycle pulse on entry to DONE.
- busy  output  1  high in ARM or RUN.
- err  output  1  sticky mismatch flag.

Behaviour:
- Reset is synchronous, active-high, clock clk_main. Reset has priority over all other inputs, including mid-operation.
- Reset values: phase=IDLE, count=0, NS=0, done=0, busy=0, err=0, start-edge history=0, ns_d=0.
- Start edge: start_rise = btn_start & ~btn_start_q, where btn_start_q is btn_start registered each cycle.
- Held btn_start produces one edge only.
- Decoding:
  - NS, busy: combinational from the phase register (NS = phase==RUN; busy = ARM or RUN).
  - done: registered.
- IDLE:
  - On start_rise with btn_stop low: go to ARM, count <= max(ARM_TICKS,1).
  - Otherwise hold; count held at 0.
- ARM:
  - btn_stop high -> IDLE, count <= 0. Stop wins over a simultaneous tick.
  - Else on tick with count==1 -> RUN, count <= max(RUN_TICKS,1).
  - Else on tick -> count-1.
- RUN:
  - btn_stop high -> IDLE, count <= 0, no done pulse.
  - Else on tick with count==1 -> DONE, count <= 0, done <= 1 for the following cycle only.
  - Else on tick -> count-1.
- DONE:
  - Stays until the next tick, then -> IDLE.
  - btn_stop high -> IDLE immediately.
  - start_rise is ignored.
- Dwell: each timed phase lasts exactly N tick pulses, where N is its load value. A tick in the same cycle as the entry transition is not counted.
- start_rise outside IDLE: ignored, and not queued.
- Counter never wraps. Decrement occurs only when count>1 or on the terminal tick.
- Mismatch check:
  - ns_d <= NS every cycle.
  - From the second cycle after reset release: if cur_state != ns_d, then err <= 1.
  - err is sticky until reset. The check is disabled in the first cycle after reset (a qualify bit is set after reset).
- Width: ARM_TICKS and RUN_TICKS must fit in W bits; truncation to W is applied at load.

Test Plan:
- Reset, then pulse btn_start for 1 cycle, then 3 ticks spaced 4 cycles apart -> phase 01 with count 3,2,1, then phase 10 with count=5 and NS=1 in the cycle after the 3rd tick.
- Continue with 5 more ticks -> count 5..1, then phase 11 with done=1 for exactly one cycle and NS=0. The next tick -> phase 00.
- btn_stop asserted in RUN with count=3, in the same cycle as a tick -> next cycle phase 00, count 0, NS 0, done stays 0.
- Hold btn_start high across a full sequence returning to IDLE -> no restart until btn_start is dropped and re-raised.
- Drive cur_state = registered NS, then force cur_state=1 for one cycle while in IDLE -> err=1 the next cycle and stays 1 until reset; reset clears err and returns phase to 00.
- Assert reset while in RUN with count=2 -> next cycle phase 00, count 0, NS 0, busy 0, err 0.
